multi_debouncer: RTL

//   Parametrised N-channel input debouncer, successor to the single-line filter.
//   - Synchronises each asynchronous input and filters glitches with a runtime threshold.
//   - Two filter modes: consecutive-stable or integrating.
//   - Emits debounced levels plus one-cycle rise/fall strobes.
//   - Sits between the pads (SCL/SDA, buttons, GPIO) and protocol logic such as the I2C bit/byte FSMs.
//

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 83 ++++++++
 rtl/multi_debouncer.sv | 42 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer family: filter-mode selectors used by
// both the per-channel filter and the multi-channel wrapper.
package debounce_pkg;

  localparam int MODE_CONSEC = 0;
  localparam int MODE_INTEG  = 1;

  // Classifies a filter decision so the strobe logic reads as intent.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_RISE,
    EV_FALL
  } edge_e;

  function automatic edge_e classify_edge(input logic switching, input logic new_level);
    if (!switching) return EV_NONE;
    return new_level ? EV_RISE : EV_FALL;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced line: synchroniser, glitch filter counter, registered level and
// one-cycle rise/fall strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   CNT_W       = 4,
  parameter logic DEFAULT     = 1'b1,
  parameter int   SYNC_STAGES = 2,
  parameter int   MODE        = MODE_CONSEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             in_i,
  output logic             out_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   switching;
  edge_e                  ev;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};

  assign switching = en_i && (s != out_q) && (cnt_q >= thresh_i);
  assign ev        = classify_edge(switching, s);

  // A match either restarts the evidence (consecutive mode) or erodes it by
  // one (integrating mode), so isolated agreeing samples only slow a switch.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en_i) begin
      if (s != out_q) begin
        if (switching) begin
          out_d  = s;
          cnt_d  = '0;
          rise_d = (ev == EV_RISE);
          fall_d = (ev == EV_FALL);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (MODE == MODE_INTEG) begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{DEFAULT}};
      cnt_q  <= '0;
      out_q  <= DEFAULT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = (s != out_q) || (cnt_q != '0);

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounce channels sharing clock, reset, sample tick and
// threshold; this level only slices the buses.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int   NUM_CH      = 2,
  parameter int   CNT_W       = 4,
  parameter logic DEFAULT     = 1'b1,
  parameter int   SYNC_STAGES = 2,
  parameter int   MODE        = MODE_CONSEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  thresh,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT    (DEFAULT),
      .SYNC_STAGES(SYNC_STAGES),
      .MODE       (MODE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .thresh_i(thresh),
      .in_i    (in[g]),
      .out_o   (out[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g]),
      .busy_o  (busy[g])
    );
  end

endmodule
